// File: rtl/im_loader_if.sv
// Byte-stream link between a host source (for example a UART receiver)
// and the instruction-memory loader.
//
// Handshake: the source drives byte_in/byte_valid, the loader drives
// byte_ready. A byte moves on a rising clock edge where byte_valid and
// byte_ready are both 1. While byte_ready is 0 the byte stays with the
// source and is offered again later. byte_ready never depends on
// byte_valid.
interface im_loader_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;

  // Host side: offers bytes.
  modport master (
    output byte_in,
    output byte_valid,
    input  byte_ready
  );

  // Loader side: accepts bytes.
  modport slave (
    input  byte_in,
    input  byte_valid,
    output byte_ready
  );
endinterface

// File: rtl/im_loader.sv
// Program loader for the single-cycle MIPS instruction memory.
//
// The loader receives a framed byte stream of the form
//   LEN_HI, LEN_LO, 4*LEN data bytes, CK
// It assembles the data bytes big-endian into 32-bit words and writes them
// to byte addresses 0, 4, 8, and so on. It also keeps an 8-bit additive
// checksum over every byte, including CK, which must sum to zero.
// The CPU stays held (cpu_hold=1) until a load completes with a good
// checksum.
module im_loader #(
  parameter int MAX_WORDS = 256,  // longest accepted image, in words (<= 65535)
  parameter int AW        = 32    // instruction-memory byte address width
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  im_loader_if.slave    bs,
  output logic          im_we,
  output logic [AW-1:0] im_addr,
  output logic [31:0]   im_wdata,
  output logic          cpu_hold,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [2:0]    dbg_state
);

  // State encoding. The encoding is visible on dbg_state for checkers.
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_HI = 3'd1;
  localparam logic [2:0] S_LEN_LO = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_CHECK  = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;
  localparam logic [2:0] S_ERROR  = 3'd7;

  localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

  // Registers
  logic [2:0]  r_state;
  logic [15:0] r_len;        // word count from the frame header
  logic [31:0] r_word;       // word being assembled, MSB byte first
  logic [15:0] r_widx;       // index of the next word to write
  logic [1:0]  r_bidx;       // bytes of the current word already received
  logic [7:0]  r_cksum;      // running 8-bit sum of the accepted bytes

  // Wires
  logic [2:0]  w_state_nx;
  logic        w_ready;
  logic        w_fire;
  logic [7:0]  w_sum;
  logic [15:0] w_len_full;
  logic        w_len_bad;
  logic [15:0] w_widx_inc;
  logic        w_start_ok;

  // The loader accepts bytes only while it is reading the header, data or
  // checksum. WRITE is a one-cycle bubble with byte_ready=0, so a word
  // write never overlaps a byte transfer.
  assign w_ready = (r_state == S_LEN_HI) || (r_state == S_LEN_LO) ||
                   (r_state == S_DATA)   || (r_state == S_CHECK);
  assign w_fire  = bs.byte_valid && w_ready;

  // The checksum wraps at 8 bits, so carries are dropped.
  assign w_sum      = r_cksum + bs.byte_in;

  // LEN is complete at the moment the low byte is accepted.
  assign w_len_full = {r_len[15:8], bs.byte_in};
  assign w_len_bad  = (w_len_full == 16'd0) || ({1'b0, w_len_full} > MAX_LEN);

  assign w_widx_inc = r_widx + 16'd1;

  // start is honoured only when the loader is idle or finished.
  assign w_start_ok = start &&
                      ((r_state == S_IDLE) || (r_state == S_DONE) ||
                       (r_state == S_ERROR));

  // Next-state logic.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_nx = S_LEN_HI;
      S_LEN_HI: if (w_fire) w_state_nx = S_LEN_LO;
      S_LEN_LO: if (w_fire) w_state_nx = w_len_bad ? S_ERROR : S_DATA;
      S_DATA:   if (w_fire && (r_bidx == 2'd3)) w_state_nx = S_WRITE;
      S_WRITE:  w_state_nx = (w_widx_inc == r_len) ? S_CHECK : S_DATA;
      S_CHECK:  if (w_fire) w_state_nx = (w_sum == 8'd0) ? S_DONE : S_ERROR;
      S_DONE:   if (start) w_state_nx = S_LEN_HI;
      S_ERROR:  if (start) w_state_nx = S_LEN_HI;
      default:  w_state_nx = S_IDLE;
    endcase
  end

  // State register. Reset aborts any load immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nx;
  end

  // Datapath: header capture, word assembly, indices and checksum.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_len   <= 16'd0;
      r_word  <= 32'd0;
      r_widx  <= 16'd0;
      r_bidx  <= 2'd0;
      r_cksum <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          // A new load starts from a clean slate. While idle, the
          // counters are held clear.
          if (w_start_ok || (r_state == S_IDLE)) begin
            r_len   <= 16'd0;
            r_word  <= 32'd0;
            r_widx  <= 16'd0;
            r_bidx  <= 2'd0;
            r_cksum <= 8'd0;
          end
        end
        S_LEN_HI: begin
          if (w_fire) begin
            r_len[15:8] <= bs.byte_in;
            r_cksum     <= w_sum;
          end
        end
        S_LEN_LO: begin
          if (w_fire) begin
            r_len[7:0] <= bs.byte_in;
            r_cksum    <= w_sum;
          end
        end
        S_DATA: begin
          if (w_fire) begin
            r_word  <= {r_word[23:0], bs.byte_in};
            r_cksum <= w_sum;
            r_bidx  <= r_bidx + 2'd1;
          end
        end
        S_WRITE: begin
          r_widx <= w_widx_inc;
          r_bidx <= 2'd0;
        end
        S_CHECK: begin
          if (w_fire) r_cksum <= w_sum;
        end
        default: begin
          r_cksum <= r_cksum;
        end
      endcase
    end
  end

  // Outputs decoded from the state. Address and data are zero outside
  // WRITE, so the memory bus is quiet between writes.
  assign bs.byte_ready = w_ready;
  assign im_we         = (r_state == S_WRITE);
  assign im_addr       = (r_state == S_WRITE) ? AW'({r_widx, 2'b00}) : '0;
  assign im_wdata      = (r_state == S_WRITE) ? r_word : 32'd0;
  assign cpu_hold      = (r_state != S_DONE);
  assign busy          = w_ready || (r_state == S_WRITE);
  assign done          = (r_state == S_DONE);
  assign err           = (r_state == S_ERROR);
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_im_loader.sv
// Testbench for im_loader. It uses a frame table with hand-chosen words,
// lengths and checksum offsets, plus hand-written sequences for reset
// during a load and for start handling.
module tb_im_loader;
  localparam int MAX_WORDS = 256;
  localparam int AW        = 32;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LEN_HI = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  logic start;
  always #5 clk = ~clk;

  im_loader_if bs ();

  logic          im_we;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_wdata;
  logic          cpu_hold, busy, done, err;
  logic [2:0]    dbg_state;

  im_loader #(.MAX_WORDS(MAX_WORDS), .AW(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bs       (bs),
    .im_we    (im_we),
    .im_addr  (im_addr),
    .im_wdata (im_wdata),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];   // {addr, data} of each expected memory write

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every write must match the expected queue in order. byte_ready must be
  // 0 during every write cycle.
  always @(negedge clk) begin
    if (!reset && im_we) begin
      check("wr_ready_low", {63'd0, bs.byte_ready}, 64'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL wr_unexpected: got addr %0h data %0h, no write expected", im_addr, im_wdata);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("wr_addr", {32'd0, im_addr}, {32'd0, e[63:32]});
        check("wr_data", {32'd0, im_wdata}, {32'd0, e[31:0]});
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [15:0]       len;
    logic [3:0][31:0]  w;         // first four words; longer images use a formula
    logic [7:0]        ck_delta;  // added to the correct CK (0 gives a good frame)
    bit                stall;     // random byte_valid gaps
    bit                poke;      // pulse start during DATA
    bit                exp_done;
    bit                exp_err;
  } vec_t;

  function automatic vec_t mk(input logic [15:0] len, input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [31:0] w3, input logic [7:0] d,
                              input bit stall, input bit poke, input bit ok);
    vec_t v;
    v.len = len; v.w = {w3, w2, w1, w0}; v.ck_delta = d;
    v.stall = stall; v.poke = poke; v.exp_done = ok; v.exp_err = !ok;
    return v;
  endfunction

  function automatic logic [31:0] word_of(input vec_t v, input int i);
    if (i < 4) return v.w[i];
    return {16'hC0DE, 16'(i)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one byte and returns just after the edge that accepted it.
  task automatic send_byte(input logic [7:0] b, input bit stall);
    int guard;
    if (stall) begin
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 1) == 0) break;
        bs.byte_valid = 1'b0;
        tick();
      end
    end
    bs.byte_in    = b;
    bs.byte_valid = 1'b1;
    guard = 0;
    @(negedge clk);
    while (!bs.byte_ready && guard < 100) begin
      guard++;
      @(negedge clk);
    end
    if (!bs.byte_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL byte_timeout: byte_ready got 0 required 1 for byte %0h", b);
    end
    tick();
    bs.byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Sends one framed image and checks the final status.
  task automatic run_frame(input vec_t v, input bit do_start, input string tag);
    logic [7:0]  ck;
    logic [31:0] w;
    int          t0;
    int          guard;
    bit          len_ok;
    ck = 8'd0;
    if (do_start) pulse_start();
    t0 = cyc;
    send_byte(v.len[15:8], v.stall); ck = ck + v.len[15:8];
    send_byte(v.len[7:0],  v.stall); ck = ck + v.len[7:0];
    len_ok = (v.len != 16'd0) && (int'(v.len) <= MAX_WORDS);
    if (len_ok) begin
      for (int i = 0; i < int'(v.len); i++) begin
        w = word_of(v, i);
        exp_q.push_back({32'(i * 4), w});
        for (int b = 3; b >= 0; b--) begin
          send_byte(w[8*b +: 8], v.stall);
          ck = ck + w[8*b +: 8];
          if (v.poke && i == 0 && b == 3) begin
            pulse_start();
            check({tag, "_poke_busy"}, {63'd0, busy}, 64'd1);
            check({tag, "_poke_state"}, {61'd0, dbg_state}, {61'd0, ST_DATA});
          end
        end
      end
      send_byte((8'd0 - ck) + v.ck_delta, v.stall);
    end
    guard = 0;
    while (!(done || err) && guard < 50) begin
      guard++;
      tick();
    end
    check({tag, "_done"},     {63'd0, done},     {63'd0, v.exp_done});
    check({tag, "_err"},      {63'd0, err},      {63'd0, v.exp_err});
    check({tag, "_cpu_hold"}, {63'd0, cpu_hold}, {63'd0, !v.exp_done});
    check({tag, "_busy"},     {63'd0, busy},     64'd0);
    tick();   // lets the monitor see any trailing write
    check({tag, "_writes_left"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    if (do_start && !v.stall && !v.poke && v.exp_done)
      check({tag, "_cycles"}, 64'(cyc - 1 - t0 + 1), 64'(5 * int'(v.len) + 4));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, {63'd0, bs.byte_ready}, 64'd0);
    check({tag, "_we"},    {63'd0, im_we},         64'd0);
    check({tag, "_addr"},  {32'd0, im_addr},       64'd0);
    check({tag, "_wdata"}, {32'd0, im_wdata},      64'd0);
    check({tag, "_hold"},  {63'd0, cpu_hold},      64'd1);
    check({tag, "_busy"},  {63'd0, busy},          64'd0);
    check({tag, "_done"},  {63'd0, done},          64'd0);
    check({tag, "_err"},   {63'd0, err},           64'd0);
    check({tag, "_state"}, {61'd0, dbg_state},     {61'd0, ST_IDLE});
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  vec_t vecs[9];

  initial begin
    // The spec image sums to 0xE3 through its last data byte, so its
    // good CK is 0x1D.
    vecs[0] = mk(16'd2, 32'h20080005, 32'hAC080000, 32'h0, 32'h0, 8'd0, 0, 0, 1);
    vecs[1] = mk(16'd2, 32'h20080005, 32'hAC080000, 32'h0, 32'h0, 8'd1, 0, 0, 0);
    vecs[2] = mk(16'd0, 32'h0, 32'h0, 32'h0, 32'h0, 8'd0, 0, 0, 0);
    vecs[3] = mk(16'(MAX_WORDS + 1), 32'h0, 32'h0, 32'h0, 32'h0, 8'd0, 0, 0, 0);
    vecs[4] = mk(16'd2, 32'h20080005, 32'hAC080000, 32'h0, 32'h0, 8'd0, 1, 0, 1);
    vecs[5] = mk(16'd1, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 8'd0, 0, 0, 1);
    vecs[6] = mk(16'd4, 32'h01234567, 32'h89ABCDEF, 32'hDEADBEEF, 32'h00000001, 8'd0, 1, 1, 1);
    vecs[7] = mk(16'(MAX_WORDS), 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 8'd0, 0, 0, 1);
    vecs[8] = mk(16'hFFFF, 32'h0, 32'h0, 32'h0, 32'h0, 8'd0, 0, 0, 0);

    reset = 1'b1;
    start = 1'b0;
    bs.byte_in    = 8'd0;
    bs.byte_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    tick();
    reset = 1'b0;
    tick();
    check_reset_outputs("idle");

    // The good image from IDLE also checks the start-to-done time.
    run_frame(vecs[0], 1'b1, "first");

    // A start in DONE re-holds the CPU and clears done on the same edge.
    start = 1'b1;
    @(negedge clk);
    check("sd_done_before", {63'd0, done},     64'd1);
    check("sd_hold_before", {63'd0, cpu_hold}, 64'd0);
    tick();
    start = 1'b0;
    check("sd_done_after",  {63'd0, done},      64'd0);
    check("sd_hold_after",  {63'd0, cpu_hold},  64'd1);
    check("sd_state_after", {61'd0, dbg_state}, {61'd0, ST_LEN_HI});
    run_frame(mk(16'd1, 32'h11223344, 32'h0, 32'h0, 32'h0, 8'd0, 0, 0, 1), 1'b0, "reload");

    for (int i = 0; i < 9; i++) run_frame(vecs[i], 1'b1, $sformatf("vec%0d", i));

    // Reset during DATA after two words have been written.
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    exp_q.push_back({32'h0, 32'hCAFEF00D});
    exp_q.push_back({32'h4, 32'h0BADBEEF});
    for (int b = 3; b >= 0; b--) send_byte(8'(32'hCAFEF00D >> (8*b)), 0);
    for (int b = 3; b >= 0; b--) send_byte(8'(32'h0BADBEEF >> (8*b)), 0);
    tick();
    send_byte(8'h77, 0);
    check("mid_state_data", {61'd0, dbg_state}, {61'd0, ST_DATA});
    check("mid_writes_seen", 64'(exp_q.size()), 64'd0);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    tick();
    reset = 1'b0;
    tick();
    run_frame(vecs[0], 1'b1, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
